// File: rtl/pif_xi_seq.sv
// pif_xi_seq: host-side sequencer between the I2C byte engine and the PIF
// register block. Turns host write bytes into an address/data pair with a
// single-clock write strobe, and turns read requests into latency-aligned
// XO captures with a stepping read sub-address.
module pif_xi_seq #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 6,
  parameter int SUBA_W = 7,
  parameter int RD_LAT = 2
) (
  input  logic              xclk,
  input  logic              sys_rst,
  input  logic              bus_start,
  input  logic              bus_stop,
  input  logic              wr_valid,
  input  logic [7:0]        wr_byte,
  input  logic              rd_req,
  input  logic              rd_done,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  output logic              err_overrun,
  output logic              XI_PWr,
  output logic [ADDR_W-1:0] XI_PRWA,
  output logic              XI_PRdFinished,
  output logic [SUBA_W-1:0] XI_PRdSubA,
  output logic [DATA_W-1:0] XI_PD,
  input  logic [7:0]        XO
);

  // Counter must hold RD_LAT; a zero latency still needs one bit.
  localparam int CNT_W = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(RD_LAT);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    DATA    = 3'd2,
    RD_WAIT = 3'd3,
    RD_HOLD = 3'd4
  } state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [7:0]        rd_data_next;
  logic              rd_valid_next;
  logic              err_next;
  logic              pwr_next;
  logic [ADDR_W-1:0] prwa_next;
  logic              fin_next;
  logic [SUBA_W-1:0] suba_next;
  logic [DATA_W-1:0] pd_next;

  // State and every output are registered so the register block sees
  // glitch-free strobes and a stable address/data pair.
  always_ff @(posedge xclk) begin
    if (sys_rst) begin
      state          <= IDLE;
      cnt            <= '0;
      rd_data        <= '0;
      rd_valid       <= 1'b0;
      err_overrun    <= 1'b0;
      XI_PWr         <= 1'b0;
      XI_PRWA        <= '0;
      XI_PRdFinished <= 1'b0;
      XI_PRdSubA     <= '0;
      XI_PD          <= '0;
    end else begin
      state          <= state_next;
      cnt            <= cnt_next;
      rd_data        <= rd_data_next;
      rd_valid       <= rd_valid_next;
      err_overrun    <= err_next;
      XI_PWr         <= pwr_next;
      XI_PRWA        <= prwa_next;
      XI_PRdFinished <= fin_next;
      XI_PRdSubA     <= suba_next;
      XI_PD          <= pd_next;
    end
  end

  // Next-state logic: START beats STOP, STOP beats byte-level events, and
  // protocol errors only set the sticky flag without disturbing anything.
  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    rd_data_next  = rd_data;
    rd_valid_next = 1'b0;
    err_next      = err_overrun;
    pwr_next      = 1'b0;
    prwa_next     = XI_PRWA;
    fin_next      = 1'b0;
    suba_next     = XI_PRdSubA;
    pd_next       = XI_PD;

    if (bus_start) begin
      state_next = ADDR;
      suba_next  = '0;
      err_next   = 1'b0;
    end else if (bus_stop) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          // Not addressed: byte-level traffic is ignored.
        end
        ADDR, DATA: begin
          if (rd_done) err_next = 1'b1;
          if (rd_req) begin
            // Reads reuse whatever address is currently held.
            state_next = RD_WAIT;
            cnt_next   = LAT_LOAD;
          end else if (wr_valid) begin
            if (state == ADDR) begin
              prwa_next  = wr_byte[ADDR_W-1:0];
              state_next = DATA;
            end else begin
              pd_next  = wr_byte[DATA_W-1:0];
              pwr_next = 1'b1;
            end
          end
        end
        RD_WAIT: begin
          if (wr_valid || rd_req || rd_done) err_next = 1'b1;
          if (cnt == '0) begin
            rd_data_next  = XO;
            rd_valid_next = 1'b1;
            state_next    = RD_HOLD;
          end else begin
            cnt_next = cnt - CNT_W'(1);
          end
        end
        RD_HOLD: begin
          if (wr_valid || rd_req) err_next = 1'b1;
          if (rd_done) begin
            fin_next   = 1'b1;
            suba_next  = XI_PRdSubA + SUBA_W'(1);
            state_next = DATA;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pif_xi_seq.sv
// Directed testbench for pif_xi_seq with a small register-block XO model.
module tb_pif_xi_seq;

  logic       xclk = 1'b0;
  logic       sys_rst, bus_start, bus_stop, wr_valid, rd_req, rd_done;
  logic [7:0] wr_byte;
  logic [7:0] rd_data;
  logic       rd_valid, err_overrun, XI_PWr, XI_PRdFinished;
  logic [5:0] XI_PRWA;
  logic [6:0] XI_PRdSubA;
  logic [5:0] XI_PD;
  logic [7:0] XO = 8'h00;
  logic [7:0] xo_d1 = 8'h00;

  int n_vec = 0;
  int n_err = 0;

  always #5 xclk = ~xclk;

  pif_xi_seq dut (
    .xclk(xclk), .sys_rst(sys_rst), .bus_start(bus_start), .bus_stop(bus_stop),
    .wr_valid(wr_valid), .wr_byte(wr_byte), .rd_req(rd_req), .rd_done(rd_done),
    .rd_data(rd_data), .rd_valid(rd_valid), .err_overrun(err_overrun),
    .XI_PWr(XI_PWr), .XI_PRWA(XI_PRWA), .XI_PRdFinished(XI_PRdFinished),
    .XI_PRdSubA(XI_PRdSubA), .XI_PD(XI_PD), .XO(XO)
  );

  // Register block readback: a fixed function of address and sub-address,
  // delayed by two registers.
  function automatic logic [7:0] xo_f(input logic [5:0] a, input logic [6:0] s);
    return {a[0], s} ^ 8'h5A;
  endfunction

  always @(posedge xclk) begin
    xo_d1 <= xo_f(XI_PRWA, XI_PRdSubA);
    XO    <= xo_d1;
  end

  task automatic tick;
    @(posedge xclk);
    #1;
  endtask

  task automatic pulse_start;
    bus_start = 1'b1;
    tick();
    bus_start = 1'b0;
  endtask

  task automatic send_wr(input logic [7:0] b);
    wr_byte  = b;
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
  endtask

  // rd_req in cycle n; rd_valid expected only in cycle n+4.
  task automatic do_read(input logic [7:0] exp);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      n_vec++;
      if (rd_valid !== 1'b0) begin
        n_err++;
        $display("FAIL read_early: rd_valid=%b at n+%0d, expected 0", rd_valid, i);
      end
      tick();
    end
    n_vec++;
    if ({rd_valid, rd_data} !== {1'b1, exp}) begin
      n_err++;
      $display("FAIL read_data: rd_valid=%b rd_data=%h, expected 1 %h", rd_valid, rd_data, exp);
    end
    tick();
    n_vec++;
    if (rd_valid !== 1'b0) begin
      n_err++;
      $display("FAIL read_pulse: rd_valid=%b one cycle later, expected 0", rd_valid);
    end
    $display("read sub=%0d data=%h", XI_PRdSubA, rd_data);
  endtask

  task automatic do_done(input logic [6:0] exp_sub);
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    n_vec++;
    if ({XI_PRdFinished, XI_PRdSubA} !== {1'b1, exp_sub}) begin
      n_err++;
      $display("FAIL done: fin=%b sub=%0d, expected 1 %0d", XI_PRdFinished, XI_PRdSubA, exp_sub);
    end
    tick();
    n_vec++;
    if (XI_PRdFinished !== 1'b0) begin
      n_err++;
      $display("FAIL done_pulse: fin=%b, expected 0", XI_PRdFinished);
    end
  endtask

  task automatic test_reset;
    logic [30:0] obs;
    sys_rst = 1'b1;
    tick(); tick();
    sys_rst = 1'b0;
    obs = {rd_data, rd_valid, err_overrun, XI_PWr, XI_PRWA, XI_PRdFinished, XI_PRdSubA, XI_PD};
    n_vec++;
    if (obs !== 31'd0) begin
      n_err++;
      $display("FAIL reset_init: outputs=%h, expected 0", obs);
    end
    // Get into RD_WAIT with nonzero state and a sticky error, then reset.
    pulse_start();
    send_wr(8'h01);
    send_wr(8'h22);
    rd_req = 1'b1;
    tick();
    tick();
    rd_req = 1'b0;
    n_vec++;
    if (err_overrun !== 1'b1) begin
      n_err++;
      $display("FAIL reset_pre_err: err=%b, expected 1", err_overrun);
    end
    sys_rst = 1'b1;
    tick(); tick();
    sys_rst = 1'b0;
    obs = {rd_data, rd_valid, err_overrun, XI_PWr, XI_PRWA, XI_PRdFinished, XI_PRdSubA, XI_PD};
    n_vec++;
    if (obs !== 31'd0) begin
      n_err++;
      $display("FAIL reset_mid_read: outputs=%h, expected 0", obs);
    end
    for (int i = 0; i < 6; i++) begin
      n_vec++;
      if (rd_valid !== 1'b0) begin
        n_err++;
        $display("FAIL reset_no_rdv: rd_valid=%b after reset, expected 0", rd_valid);
      end
      tick();
    end
    // IDLE ignores writes and rd_done.
    send_wr(8'h3F);
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    n_vec++;
    if ({XI_PWr, XI_PRWA, XI_PD, err_overrun} !== {1'b0, 6'h00, 6'h00, 1'b0}) begin
      n_err++;
      $display("FAIL reset_idle: pwr=%b prwa=%h pd=%h err=%b, expected 0 00 00 0",
               XI_PWr, XI_PRWA, XI_PD, err_overrun);
    end
    $display("reset done");
  endtask

  task automatic test_write;
    pulse_start();
    send_wr(8'h01);
    n_vec++;
    if ({XI_PWr, XI_PRWA} !== {1'b0, 6'h01}) begin
      n_err++;
      $display("FAIL wr_addr: pwr=%b prwa=%h, expected 0 01", XI_PWr, XI_PRWA);
    end
    send_wr(8'h2A);
    n_vec++;
    if ({XI_PWr, XI_PRWA, XI_PD} !== {1'b1, 6'h01, 6'h2A}) begin
      n_err++;
      $display("FAIL wr_data1: pwr=%b prwa=%h pd=%h, expected 1 01 2a", XI_PWr, XI_PRWA, XI_PD);
    end
    tick();
    n_vec++;
    if (XI_PWr !== 1'b0) begin
      n_err++;
      $display("FAIL wr_pulse1: pwr=%b, expected 0", XI_PWr);
    end
    send_wr(8'h15);
    n_vec++;
    if ({XI_PWr, XI_PRWA, XI_PD} !== {1'b1, 6'h01, 6'h15}) begin
      n_err++;
      $display("FAIL wr_data2: pwr=%b prwa=%h pd=%h, expected 1 01 15", XI_PWr, XI_PRWA, XI_PD);
    end
    tick();
    n_vec++;
    if ({XI_PWr, XI_PD} !== {1'b0, 6'h15}) begin
      n_err++;
      $display("FAIL wr_pulse2: pwr=%b pd=%h, expected 0 15", XI_PWr, XI_PD);
    end
    $display("write addr=%h data=2a,15", XI_PRWA);
  endtask

  task automatic test_read;
    logic [7:0] exp_tab [4];
    exp_tab = '{8'h5A, 8'h5B, 8'h58, 8'h59};
    pulse_start();
    send_wr(8'h00);
    for (int k = 0; k < 4; k++) begin
      do_read(exp_tab[k]);
      do_done(7'(k + 1));
    end
  endtask

  task automatic test_wrap;
    pulse_start();
    send_wr(8'h00);
    for (int s = 0; s < 127; s++) begin
      do_read(xo_f(6'd0, 7'(s)));
      do_done(7'(s + 1));
    end
    n_vec++;
    if (XI_PRdSubA !== 7'd127) begin
      n_err++;
      $display("FAIL wrap_127: sub=%0d, expected 127", XI_PRdSubA);
    end
    do_read(8'h25);
    do_done(7'd0);
  endtask

  task automatic test_overrun;
    pulse_start();
    send_wr(8'h03);
    rd_req = 1'b1;
    tick();
    tick();
    rd_req = 1'b0;
    n_vec++;
    if ({err_overrun, rd_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL ovr_rdreq: err=%b rdv=%b, expected 1 0", err_overrun, rd_valid);
    end
    tick();
    n_vec++;
    if (rd_valid !== 1'b0) begin
      n_err++;
      $display("FAIL ovr_early: rd_valid=%b, expected 0", rd_valid);
    end
    tick();
    n_vec++;
    if ({rd_valid, rd_data} !== {1'b1, 8'hDA}) begin
      n_err++;
      $display("FAIL ovr_data: rdv=%b data=%h, expected 1 da", rd_valid, rd_data);
    end
    tick();
    send_wr(8'h3F);
    n_vec++;
    if ({XI_PWr, XI_PD, err_overrun, rd_valid} !== {1'b0, 6'h15, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL ovr_wr: pwr=%b pd=%h err=%b rdv=%b, expected 0 15 1 0",
               XI_PWr, XI_PD, err_overrun, rd_valid);
    end
    tick();
    n_vec++;
    if ({XI_PWr, rd_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL ovr_quiet: pwr=%b rdv=%b, expected 0 0", XI_PWr, rd_valid);
    end
    pulse_start();
    n_vec++;
    if (err_overrun !== 1'b0) begin
      n_err++;
      $display("FAIL ovr_clear: err=%b, expected 0", err_overrun);
    end
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    n_vec++;
    if ({err_overrun, XI_PRdFinished} !== 2'b10) begin
      n_err++;
      $display("FAIL ovr_done_addr: err=%b fin=%b, expected 1 0", err_overrun, XI_PRdFinished);
    end
    pulse_start();
    n_vec++;
    if (err_overrun !== 1'b0) begin
      n_err++;
      $display("FAIL ovr_clear2: err=%b, expected 0", err_overrun);
    end
    $display("overrun checks done");
  endtask

  task automatic test_conflicts;
    pulse_start();
    send_wr(8'h00);
    do_read(8'h5A);
    rd_done  = 1'b1;
    bus_stop = 1'b1;
    tick();
    rd_done  = 1'b0;
    bus_stop = 1'b0;
    n_vec++;
    if ({XI_PRdFinished, XI_PRdSubA} !== {1'b0, 7'd0}) begin
      n_err++;
      $display("FAIL stop_done: fin=%b sub=%0d, expected 0 0", XI_PRdFinished, XI_PRdSubA);
    end
    // Now IDLE: a read request must be ignored without error.
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if ({rd_valid, err_overrun, XI_PRdFinished} !== 3'b000) begin
        n_err++;
        $display("FAIL stop_idle: rdv=%b err=%b fin=%b, expected 0 0 0",
                 rd_valid, err_overrun, XI_PRdFinished);
      end
      tick();
    end
    pulse_start();
    bus_start = 1'b1;
    wr_valid  = 1'b1;
    wr_byte   = 8'h05;
    tick();
    bus_start = 1'b0;
    wr_valid  = 1'b0;
    n_vec++;
    if (XI_PRWA !== 6'h00) begin
      n_err++;
      $display("FAIL start_wr: prwa=%h, expected 00", XI_PRWA);
    end
    send_wr(8'h07);
    n_vec++;
    if ({XI_PWr, XI_PRWA} !== {1'b0, 6'h07}) begin
      n_err++;
      $display("FAIL start_wr_addr: pwr=%b prwa=%h, expected 0 07", XI_PWr, XI_PRWA);
    end
    bus_start = 1'b1;
    bus_stop  = 1'b1;
    tick();
    bus_start = 1'b0;
    bus_stop  = 1'b0;
    send_wr(8'h09);
    n_vec++;
    if ({XI_PWr, XI_PRWA} !== {1'b0, 6'h09}) begin
      n_err++;
      $display("FAIL start_stop: pwr=%b prwa=%h, expected 0 09", XI_PWr, XI_PRWA);
    end
    bus_stop = 1'b1;
    wr_valid = 1'b1;
    wr_byte  = 8'h11;
    tick();
    bus_stop = 1'b0;
    wr_valid = 1'b0;
    n_vec++;
    if ({XI_PWr, XI_PD} !== {1'b0, 6'h15}) begin
      n_err++;
      $display("FAIL stop_wr: pwr=%b pd=%h, expected 0 15", XI_PWr, XI_PD);
    end
    $display("conflict checks done");
  endtask

  initial begin
    sys_rst   = 1'b1;
    bus_start = 1'b0;
    bus_stop  = 1'b0;
    wr_valid  = 1'b0;
    wr_byte   = 8'h00;
    rd_req    = 1'b0;
    rd_done   = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_wrap();
    test_overrun();
    test_conflicts();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/pif_xi_seq.md
Name: pif_xi_seq

Overview:
- Host-side sequencer that drives the XI register-access record consumed by the PIF control/register block, and returns that block's XO readback byte.
- Sits between the I2C byte-level slave engine and the register block.
- Converts a write-address/data byte stream into registered single-clock write strobes and a stable address/data pair.
- Converts host read requests into a stepped read sub-address, latency-aligned XO sampling and PRdFinished pulses.

Parameters:
ADDR_W, 6, width of XI_PRWA; taken from the low bits of the first written byte.
DATA_W, 6, width of XI_PD (I2C_DATA_BITS); taken from the low bits of each data byte.
SUBA_W, 7, width of XI_PRdSubA; the counter wraps at 2**SUBA_W.
RD_LAT, 2, clocks from a stable XI_PRWA/XI_PRdSubA to a valid XO.

Ports:
xclk  in  1  system clock
sys_rst  in  1  synchronous, active-high reset
bus_start  in  1  pulse: I2C START or repeated START addressed to this device
bus_stop  in  1  pulse: I2C STOP
wr_valid  in  1  pulse: one host write byte received
wr_byte  in  8  host write byte, valid with wr_valid
rd_req  in  1  pulse: transmitter needs the next read byte
rd_done  in  1  pulse: current read byte shifted out and host ACK/NACK sampled
rd_data  out  8  byte for the transmitter, held until next load
rd_valid  out  1  one-cycle pulse: rd_data newly loaded
err_overrun  out  1  sticky protocol error; cleared by bus_start
XI_PWr  out  1  registered single-clock write strobe
XI_PRWA  out  ADDR_W  registered read/write address
XI_PRdFinished  out  1  one-cycle pulse: read byte consumed
XI_PRdSubA  out  SUBA_W  read sub-address
XI_PD  out  DATA_W  registered write data
XO  in  8  readback byte from the register block

Behaviour:
- Reset: sys_rst sampled high at a posedge forces state IDLE.
  - Cleared to 0 on reset: all outputs, the latency counter and err_overrun.
  - sys_rst dominates every other input.
- States: IDLE, ADDR, DATA, RD_WAIT, RD_HOLD.
- bus_start, in any state: next state ADDR, XI_PRdSubA <= 0, err_overrun <= 0.
  - Any other input in the same cycle is dropped.
- IDLE: wr_valid, rd_req and rd_done are ignored with no error.
- ADDR, on wr_valid: XI_PRWA <= wr_byte[ADDR_W-1:0], go DATA.
- DATA, on wr_valid:
  - XI_PD <= wr_byte[DATA_W-1:0] and XI_PWr = 1 for exactly the next cycle.
  - XI_PD and XI_PRWA are stable while XI_PWr is high.
  - XI_PRWA does not auto-increment.
- Write latency: wr_valid at cycle n gives XI_PWr high in cycle n+1 only.
- rd_req in ADDR or DATA: go RD_WAIT and load the counter with RD_LAT.
  - A read with no address byte uses the retained XI_PRWA.
- RD_WAIT: the counter decrements each cycle. In the cycle it is 0:
  - rd_data <= XO and rd_valid = 1 next cycle;
  - go RD_HOLD.
- Read latency: rd_req at cycle n gives rd_valid in cycle n+RD_LAT+2.
  - XO is sampled at the end of cycle n+RD_LAT+1.
- RD_HOLD, on rd_done:
  - XI_PRdFinished = 1 for the next cycle;
  - XI_PRdSubA increments by 1 in the same cycle (wrapping 2**SUBA_W-1 -> 0);
  - go DATA.
- rd_req in RD_HOLD after rd_done: handled as in DATA, i.e. a fresh RD_LAT wait with the new sub-address.
- Errors (sticky, no state change, nothing else happens):
  - wr_valid in RD_WAIT or RD_HOLD;
  - rd_req in RD_WAIT or RD_HOLD;
  - rd_done in any state other than RD_HOLD and IDLE.
- bus_stop, in any state: go IDLE.
  - Retained: XI_PRWA, XI_PD, XI_PRdSubA, rd_data.
  - A pending RD_WAIT is aborted with no rd_valid.
- Same-cycle conflicts:
  - bus_start with bus_stop: start wins.
  - bus_stop with wr_valid, rd_req or rd_done: stop wins, and the event is dropped.
- Strobes: XI_PWr, XI_PRdFinished and rd_valid are never high for two consecutive cycles from a single event.

Test Plan:
- Reset: hold sys_rst 2 cycles mid-RD_WAIT -> all outputs 0, state IDLE, no rd_valid afterwards.
- Write: bus_start; wr_byte 0x01; wr_byte 0x2A; wr_byte 0x15 -> XI_PRWA=0x01 and XI_PWr pulses twice, with XI_PD=0x2A then 0x15, each pulse exactly 1 cycle after its wr_valid.
- Read sequence: XI_PRWA=0x00, model XO=f(sub) with 2-register delay; bus_start; wr 0x00; rd_req/rd_done x4 -> rd_data at sub 0,1,2,3 matches the model; rd_valid at rd_req+4 cycles; XI_PRdSubA 0->4; four XI_PRdFinished pulses.
- Sub-address wrap: force 127 reads -> after the 128th rd_done XI_PRdSubA=0.
- Overrun: rd_req again during RD_WAIT, and wr_valid during RD_HOLD -> err_overrun=1, no extra rd_valid or XI_PWr; next bus_start clears it.
- Conflicts: bus_stop with rd_done -> no XI_PRdFinished, state IDLE, XI_PRdSubA unchanged. bus_start with wr_valid 0x05 -> byte dropped, XI_PRWA unchanged.
